// File: rtl/serial_tx_if.sv
// Upstream word handshake into the serial transmitter.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start(0), data LSB first, optional even parity, stop(1).
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | driving start bit (0)
// DATA   | shifting data bits out LSB first
// PARITY | driving even-parity bit
// STOP   | driving stop bit (1)
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic           clk,
    input  logic           reset,
    serial_tx_if.slave     tx_if,
    output logic           tx_out,
    output logic           busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              parity;
    logic              last_clk;
    logic              last_idx;

    assign tx_if.tx_ready = (state == IDLE);
    assign shreg_next     = shreg >> 1;
    assign last_clk       = (bit_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_idx       = (idx == IW'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            if (state != IDLE) begin
                bit_cnt <= last_clk ? '0 : bit_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tx_if.tx_valid) begin
                        shreg   <= tx_if.tx_data;
                        parity  <= ^tx_if.tx_data;
                        bit_cnt <= '0;
                        idx     <= '0;
                        tx_out  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (last_clk) begin
                        tx_out <= shreg[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (last_clk) begin
                        if (last_idx) begin
                            if (PARITY_EN != 0) begin
                                tx_out <= parity;
                                state  <= PARITY;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            // next data bit comes from the word after this shift
                            shreg  <= shreg_next;
                            tx_out <= shreg_next[0];
                            idx    <= idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (last_clk) begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (last_clk) begin
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default instance plus a CLKS_PER_BIT=1, no-parity instance.
module tb_serial_tx;
    logic clk;
    logic reset;
    logic tx_out0, busy0, tx_out1, busy1;
    int   n_checks;
    int   n_err;
    logic q0[$];
    logic q1[$];
    time  t_a, t_b;

    serial_tx_if #(.DATA_W(8)) if0 ();
    serial_tx_if #(.DATA_W(8)) if1 ();

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk(clk), .reset(reset), .tx_if(if0.slave), .tx_out(tx_out0), .busy(busy0)
    );
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk(clk), .reset(reset), .tx_if(if1.slave), .tx_out(tx_out1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected per-cycle line values for one frame, starting the cycle after acceptance
    task automatic push_frame(input int sel, input logic [7:0] d);
        int  cpb;
        bit  par;
        cpb = (sel == 0) ? 4 : 1;
        par = (sel == 0);
        for (int c = 0; c < cpb; c++) if (sel == 0) q0.push_back(1'b0); else q1.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < cpb; c++) if (sel == 0) q0.push_back(d[i]); else q1.push_back(d[i]);
        if (par)
            for (int c = 0; c < cpb; c++) q0.push_back(^d);
        for (int c = 0; c < cpb; c++) if (sel == 0) q0.push_back(1'b1); else q1.push_back(1'b1);
    endtask

    task automatic accept(input int sel, input logic [7:0] d, input bit hold, output time t);
        int n;
        n = 0;
        if (sel == 0) begin if0.tx_valid = 1'b1; if0.tx_data = d; end
        else          begin if1.tx_valid = 1'b1; if1.tx_data = d; end
        while (((sel == 0) ? if0.tx_ready : if1.tx_ready) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        t = $time;
        push_frame(sel, d);
        #1;
        if (!hold) begin
            if (sel == 0) if0.tx_valid = 1'b0; else if1.tx_valid = 1'b0;
        end
    endtask

    task automatic check_cycles(input int sel, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                e = q0.pop_front();
                chk($sformatf("tx0_bit%0d", i), {31'd0, tx_out0}, {31'd0, e});
                chk($sformatf("busy0_%0d", i), {31'd0, busy0}, 32'd1);
                chk($sformatf("ready0_%0d", i), {31'd0, if0.tx_ready}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk($sformatf("tx1_bit%0d", i), {31'd0, tx_out1}, {31'd0, e});
                chk($sformatf("busy1_%0d", i), {31'd0, busy1}, 32'd1);
            end
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_line", {31'd0, tx_out0}, 32'd1);
            chk("idle_busy", {31'd0, busy0}, 32'd0);
            chk("idle_ready", {31'd0, if0.tx_ready}, 32'd1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset = 1'b0;
        if0.tx_valid = 1'b0; if0.tx_data = 8'h00;
        if1.tx_valid = 1'b0; if1.tx_data = 8'h00;
        #12;
        chk("rst_tx_out", {31'd0, tx_out0}, 32'd1);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_ready", {31'd0, if0.tx_ready}, 32'd1);
        @(negedge clk); reset = 1'b1;
        check_idle(2);

        // 1: 0xA5, 44-cycle frame with parity 0
        accept(0, 8'hA5, 1'b0, t_a);
        check_cycles(0, 44);
        check_idle(1);

        // 2: 0x01 then 0xFF with idle gap
        accept(0, 8'h01, 1'b0, t_a);
        check_cycles(0, 44);
        check_idle(3);
        accept(0, 8'hFF, 1'b0, t_a);
        check_cycles(0, 44);
        check_idle(2);

        // 3: back-to-back with valid held
        accept(0, 8'h3C, 1'b1, t_a);
        if0.tx_data = 8'hC3;
        check_cycles(0, 44);
        @(negedge clk);
        chk("b2b_gap_line", {31'd0, tx_out0}, 32'd1);
        chk("b2b_gap_ready", {31'd0, if0.tx_ready}, 32'd1);
        accept(0, 8'hC3, 1'b0, t_b);
        chk("b2b_spacing", 32'((t_b - t_a) / 10), 32'd45);
        check_cycles(0, 44);
        check_idle(1);

        // 4: reset during data bit 3 of 0x5A
        accept(0, 8'h5A, 1'b0, t_a);
        check_cycles(0, 4 + 12 + 2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_tx_out", {31'd0, tx_out0}, 32'd1);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_ready", {31'd0, if0.tx_ready}, 32'd1);
        q0.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        check_idle(1);
        accept(0, 8'h81, 1'b0, t_a);
        check_cycles(0, 44);
        check_idle(1);

        // 5: tx_data changes right after acceptance
        accept(0, 8'hF0, 1'b0, t_a);
        if0.tx_data = 8'h00;
        check_cycles(0, 44);
        check_idle(1);

        // 6: one clock per bit, no parity, valid held across two frames
        accept(1, 8'h96, 1'b1, t_a);
        chk("p1_frame_len", q1.size(), 32'd10);
        check_cycles(1, 10);
        @(negedge clk);
        chk("p1_gap_line", {31'd0, tx_out1}, 32'd1);
        chk("p1_gap_busy", {31'd0, busy1}, 32'd0);
        accept(1, 8'h96, 1'b0, t_b);
        chk("p1_spacing", 32'((t_b - t_a) / 10), 32'd11);
        check_cycles(1, 10);
        @(negedge clk);
        chk("p1_end_line", {31'd0, tx_out1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
